// File: rtl/aes_round_sequencer_if.sv
// Signal bundle between the AES round sequencer and its front end, key schedule and Sub_Bytes
// engine. The sequencer takes the master side; everything around it takes the slave side.
interface aes_round_sequencer_if;
    logic         start;
    logic [127:0] block_in;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] block_out;

    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_ack;
    logic [127:0] rk_data;

    logic         sb_start;
    logic [127:0] sb_data_in;
    logic         sb_done;
    logic [127:0] sb_data_out;

    modport master (
        input  start, block_in, rk_ack, rk_data, sb_done, sb_data_out,
        output busy, done, err, block_out, rk_req, rk_idx, sb_start, sb_data_in
    );

    modport slave (
        output start, block_in, rk_ack, rk_data, sb_done, sb_data_out,
        input  busy, done, err, block_out, rk_req, rk_idx, sb_start, sb_data_in
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Sequences one AES-128 block encryption: owns the state register, AddRoundKey, ShiftRows and
// MixColumns; round keys come over rk_req/rk_ack and SubBytes is borrowed via sb_start/sb_done.
module aes_round_sequencer #(
    parameter int unsigned NR         = 10,
    parameter int unsigned SB_TIMEOUT = 255
) (
    input logic                   ACLK,
    input logic                   ARESETN,
    aes_round_sequencer_if.master bus
);

    typedef enum logic [2:0] {StIdle, StKey, StSub, StWait, StMix, StDone} state_e;

    localparam logic [3:0] LastRound   = 4'(NR);
    localparam logic [7:0] TimeoutLast = 8'(SB_TIMEOUT - 1);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the block sits at [127-8i -: 8]; row = i%4, column = i/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+row)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return r;
    endfunction

    state_e       st_q, st_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] out_q, out_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         rk_req, sb_start, done, err;

    always_comb begin
        st_d     = st_q;
        blk_d    = blk_q;
        out_d    = out_q;
        round_d  = round_q;
        cnt_d    = cnt_q;
        rk_req   = 1'b0;
        sb_start = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (bus.start) begin
                    blk_d   = bus.block_in;
                    round_d = '0;
                    st_d    = StKey;
                end
            end
            StKey: begin
                rk_req = 1'b1;
                if (bus.rk_ack) begin
                    blk_d = blk_q ^ bus.rk_data;
                    if (round_q == LastRound) begin
                        st_d = StDone;
                    end else begin
                        round_d = round_q + 4'd1;
                        st_d    = StSub;
                    end
                end
            end
            StSub: begin
                sb_start = 1'b1;
                cnt_d    = '0;
                st_d     = StWait;
            end
            StWait: begin
                // A result arriving in the timeout cycle still counts.
                if (bus.sb_done) begin
                    blk_d = bus.sb_data_out;
                    st_d  = StMix;
                end else if (cnt_q == TimeoutLast) begin
                    err  = 1'b1;
                    st_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StMix: begin
                blk_d = (round_q == LastRound) ? shift_rows(blk_q)
                                               : mix_columns(shift_rows(blk_q));
                st_d  = StKey;
            end
            StDone: begin
                done  = 1'b1;
                out_d = blk_q;
                st_d  = StIdle;
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            st_q    <= StIdle;
            blk_q   <= '0;
            out_q   <= '0;
            round_q <= '0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            blk_q   <= blk_d;
            out_q   <= out_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy       = (st_q != StIdle);
    assign bus.done       = done;
    assign bus.err        = err;
    // The ciphertext is visible in the same cycle as done, then held by out_q.
    assign bus.block_out  = (st_q == StDone) ? blk_q : out_q;
    assign bus.rk_req     = rk_req;
    assign bus.rk_idx     = round_q;
    assign bus.sb_start   = sb_start;
    assign bus.sb_data_in = blk_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Randomised bench for aes_round_sequencer: emulates the key schedule and Sub_Bytes engine and
// checks ciphertext, latency and handshake behaviour against a byte-level AES reference model.
module tb_aes_round_sequencer;
    localparam int unsigned NR         = 10;
    localparam int unsigned SB_TIMEOUT = 255;

    logic ACLK    = 1'b0;
    logic ARESETN = 1'b0;

    aes_round_sequencer_if bus ();

    aes_round_sequencer #(
        .NR        (NR),
        .SB_TIMEOUT(SB_TIMEOUT)
    ) u_dut (
        .ACLK   (ACLK),
        .ARESETN(ARESETN),
        .bus    (bus)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox   [256];
    logic [127:0] rk_tab [16];

    int  rk_max_stall = 0;
    bit  rk_tie_high  = 1'b0;
    int  rk_stall     = 0;
    int  sb_lat_min   = 1;
    int  sb_lat_max   = 1;
    int  sb_withhold  = -1;

    int  rk_stall_sum = 0;
    int  sb_lat_sum   = 0;
    int  sb_pulses    = 0;
    logic [3:0] idx_log [$];

    int  ncyc        = 0;
    int  done_cnt    = 0;
    int  err_cnt     = 0;
    int  last_sb_cyc = 0;
    int  err_cyc     = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] sub_bytes_f(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox[x[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk_tab[r] = '0;
        for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] out;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_tab[0][127-8*i -: 8];
        for (int r = 1; r <= int'(NR); r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[row+4*c] = s[row+4*((c+row)%4)];
            for (int c = 0; c < 4; c++) begin
                if (r < int'(NR)) begin
                    s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end else begin
                    for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_tab[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    // Key-schedule responder: random stalls, or ack held high; stray acks while not requested.
    initial begin
        bus.rk_ack  = 1'b0;
        bus.rk_data = '0;
        forever begin
            @(negedge ACLK);
            if (rk_tie_high) begin
                bus.rk_ack  = 1'b1;
                bus.rk_data = rk_tab[bus.rk_idx];
                if (bus.rk_req) idx_log.push_back(bus.rk_idx);
            end else if (bus.rk_req) begin
                if (rk_stall == 0) begin
                    bus.rk_ack  = 1'b1;
                    bus.rk_data = rk_tab[bus.rk_idx];
                    idx_log.push_back(bus.rk_idx);
                    rk_stall = int'($urandom_range(rk_max_stall, 0));
                end else begin
                    bus.rk_ack  = 1'b0;
                    bus.rk_data = rand128();
                    rk_stall--;
                    rk_stall_sum++;
                end
            end else begin
                bus.rk_ack  = ($urandom_range(3, 0) == 0);
                bus.rk_data = rand128();
            end
        end
    end

    // Sub_Bytes responder: latency sb_lat_min..max, optional withheld pulse, stray dones when idle.
    initial begin
        int           sb_cnt;
        bit           sb_idle;
        logic [127:0] sb_res;
        sb_cnt  = 0;
        sb_idle = 1'b1;
        sb_res  = '0;
        bus.sb_done     = 1'b0;
        bus.sb_data_out = '0;
        forever begin
            @(negedge ACLK);
            bus.sb_done     = 1'b0;
            bus.sb_data_out = rand128();
            if (bus.sb_start) begin
                sb_pulses++;
                sb_res  = sub_bytes_f(bus.sb_data_in);
                sb_idle = 1'b0;
                if (sb_pulses == sb_withhold) begin
                    sb_cnt = 0;
                end else begin
                    sb_cnt     = int'($urandom_range(sb_lat_max, sb_lat_min));
                    sb_lat_sum += sb_cnt;
                end
            end else if (sb_cnt > 0) begin
                sb_cnt--;
                if (sb_cnt == 0) begin
                    bus.sb_done     = 1'b1;
                    bus.sb_data_out = sb_res;
                    sb_idle         = 1'b1;
                end
            end else if (sb_idle && $urandom_range(5, 0) == 0) begin
                bus.sb_done = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge ACLK);
            ncyc++;
            if (bus.sb_start) last_sb_cyc = ncyc;
            if (bus.done) done_cnt++;
            if (bus.err) begin
                err_cnt++;
                err_cyc = ncyc;
            end
        end
    end

    // One encryption; cycle 0 is the cycle start is sampled, lat is the cycle done/err is seen.
    task automatic run_enc(input logic [127:0] pt, input int withhold_rel, input int poke_at,
                           output logic [127:0] ct, output int lat, output int exp_lat,
                           output bit got_done, output bit got_err, output int idx_base);
        int lat_base;
        int stall_base;
        int n;
        @(negedge ACLK);
        lat_base    = sb_lat_sum;
        stall_base  = rk_stall_sum;
        idx_base    = idx_log.size();
        sb_withhold = (withhold_rel > 0) ? sb_pulses + withhold_rel : -1;
        ct          = '0;
        lat         = 0;
        got_done    = 1'b0;
        got_err     = 1'b0;
        bus.start    = 1'b1;
        bus.block_in = pt;
        @(negedge ACLK);
        n = 1;
        while (n <= 2000) begin
            if (bus.done) begin
                got_done = 1'b1;
                ct       = bus.block_out;
                lat      = n;
                break;
            end
            if (bus.err) begin
                got_err = 1'b1;
                lat     = n;
                break;
            end
            bus.start    = (poke_at > 0) && ((n == poke_at) || (n == poke_at + 7));
            bus.block_in = rand128();
            @(negedge ACLK);
            n++;
        end
        bus.start = 1'b0;
        exp_lat = 2 + 3 * int'(NR) + (sb_lat_sum - lat_base) + (rk_stall_sum - stall_base);
    endtask

    initial begin
        logic [127:0] key, pt, ct, prev_ct;
        int           lat, exp_lat, idx_base, base, n, done_base, err_base;
        bit           got_done, got_err;

        bus.start    = 1'b0;
        bus.block_in = '0;
        build_sbox();

        repeat (3) @(negedge ACLK);
        check_eq("reset_ctrl", 128'({bus.busy, bus.done, bus.err, bus.rk_req, bus.sb_start,
                                      bus.rk_idx}), '0);
        check_eq("reset_block_out", bus.block_out, '0);
        check_eq("reset_sb_data_in", bus.sb_data_in, '0);
        ARESETN = 1'b1;

        // FIPS-197 Appendix B, zero-wait key, L=1.
        expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        pt = 128'h3243f6a8885a308d313198a2e0370734;
        run_enc(pt, 0, 0, ct, lat, exp_lat, got_done, got_err, idx_base);
        check_eq("kat_b_done", 128'(got_done), 128'(1));
        check_eq("kat_b_ct", ct, 128'h3925841d02dc09fbdc118597196a0b32);
        check_eq("kat_b_model", ct, aes_model(pt));
        check_eq("kat_b_latency", 128'(lat), 128'(42));

        // FIPS-197 C.1 with rk_ack tied high.
        rk_tie_high = 1'b1;
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        run_enc(128'h00112233445566778899aabbccddeeff, 0, 0, ct, lat, exp_lat, got_done, got_err,
                idx_base);
        check_eq("kat_c1_done", 128'(got_done), 128'(1));
        check_eq("kat_c1_ct", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check_eq("kat_c1_latency", 128'(lat), 128'(42));
        rk_tie_high = 1'b0;

        // Appendix B again under random key stalls and Sub_Bytes latency.
        rk_max_stall = 5;
        sb_lat_min   = 1;
        sb_lat_max   = 8;
        expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        base = sb_pulses;
        run_enc(128'h3243f6a8885a308d313198a2e0370734, 0, 0, ct, lat, exp_lat, got_done, got_err,
                idx_base);
        check_eq("stall_ct", ct, 128'h3925841d02dc09fbdc118597196a0b32);
        check_eq("stall_latency", 128'(lat), 128'(exp_lat));
        check_eq("stall_sb_pulses", 128'(sb_pulses - base), 128'(NR));
        check_eq("stall_rk_count", 128'(idx_log.size() - idx_base), 128'(NR + 1));
        for (int i = 0; i <= int'(NR); i++) begin
            check_eq($sformatf("stall_rk_idx%0d", i), 128'(idx_log[idx_base + i]), 128'(i));
        end

        for (int k = 0; k < 3; k++) begin
            key = rand128();
            pt  = rand128();
            expand_key(key);
            run_enc(pt, 0, 0, ct, lat, exp_lat, got_done, got_err, idx_base);
            check_eq($sformatf("rand%0d_ct", k), ct, aes_model(pt));
            check_eq($sformatf("rand%0d_latency", k), 128'(lat), 128'(exp_lat));
        end
        prev_ct = ct;

        // Sub_Bytes result withheld in round 3.
        err_base = err_cnt;
        run_enc(rand128(), 3, 0, ct, lat, exp_lat, got_done, got_err, idx_base);
        check_eq("timeout_err", 128'({got_err, got_done}), 128'(2'b10));
        check_eq("timeout_wait_cycles", 128'(err_cyc - last_sb_cyc), 128'(SB_TIMEOUT));
        check_eq("timeout_block_out", bus.block_out, prev_ct);
        @(negedge ACLK);
        check_eq("timeout_idle_after", 128'({bus.busy, bus.err}), '0);
        check_eq("timeout_err_count", 128'(err_cnt - err_base), 128'(1));
        check_eq("timeout_block_out_held", bus.block_out, prev_ct);
        pt = rand128();
        run_enc(pt, 0, 0, ct, lat, exp_lat, got_done, got_err, idx_base);
        check_eq("after_timeout_ct", ct, aes_model(pt));

        // start pulsed while busy must be ignored.
        done_base = done_cnt;
        pt        = rand128();
        run_enc(pt, 0, 10, ct, lat, exp_lat, got_done, got_err, idx_base);
        check_eq("busy_start_ct", ct, aes_model(pt));
        check_eq("busy_start_latency", 128'(lat), 128'(exp_lat));
        repeat (60) @(negedge ACLK);
        check_eq("busy_start_one_done", 128'(done_cnt - done_base), 128'(1));
        check_eq("busy_start_idle", 128'(bus.busy), '0);

        // Asynchronous reset in round 5.
        pt = rand128();
        @(negedge ACLK);
        base         = sb_pulses;
        bus.start    = 1'b1;
        bus.block_in = pt;
        @(negedge ACLK);
        bus.start = 1'b0;
        n = 0;
        while (sb_pulses < base + 5 && n < 500) begin
            @(negedge ACLK);
            n++;
        end
        check_eq("rst_reached_round5", 128'(sb_pulses >= base + 5), 128'(1));
        #2 ARESETN = 1'b0;
        #1;
        check_eq("rst_async_ctrl", 128'({bus.busy, bus.done, bus.err, bus.rk_req, bus.sb_start,
                                          bus.rk_idx}), '0);
        check_eq("rst_async_block_out", bus.block_out, '0);
        check_eq("rst_async_sb_data_in", bus.sb_data_in, '0);
        @(negedge ACLK);
        check_eq("rst_held_busy", 128'(bus.busy), '0);
        ARESETN = 1'b1;
        pt = rand128();
        run_enc(pt, 0, 0, ct, lat, exp_lat, got_done, got_err, idx_base);
        check_eq("after_reset_done", 128'(got_done), 128'(1));
        check_eq("after_reset_ct", ct, aes_model(pt));
        check_eq("after_reset_latency", 128'(lat), 128'(exp_lat));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
